pc_gen: RTL and testbench
=========================

# pc_gen

Instruction-fetch PC generator, the stage directly upstream of the instruction-cache stage register. Holds the fetch PC, selects the next PC from sequential increment, branch redirect, or exception/flush target, and drives the instruction SRAM request. It produces `pc_to_ic_bus` for the IC stage. Branch redirects that arrive while the PC is stalled are buffered and applied when the stall releases.

## Interface
- `RESET_VEC` (default 32'hBFC0_0000): first fetched PC after reset.
- `clk` input, 1: clock.
- `rst` input, 1: synchronous, active-high reset.
- `stall` input, `StallBus`: `stall[0]==Stop` freezes the PC.
- `flush` input, 1: exception/ERET flush.
- `new_pc` input, 32: flush target, valid with `flush`.
- `br_e` input, 1: branch/jump taken, from EX.
- `br_addr` input, 32: branch target, valid with `br_e`.
- `pc_to_ic_bus` output, `PC_TO_IC_WD` (65): {excepttype[31:0] 64:33, ce 32, pc 31:0}.
- `inst_sram_en` output, 1: fetch request.
- `inst_sram_addr` output, 32: fetch address.

## Operation
- Registers:
  - `pc` (32)
  - `ce` (1)
  - `pend` (1)
  - `pend_addr` (32)
- Reset, registered on a clock edge with `rst`=1:
  - `pc`=RESET_VEC-4
  - `ce`=0
  - `pend`=0
  - `pend_addr`=0
- Priority at each posedge with `rst`=0; `ce`<=1 in every case:
  1. `flush`: `pc`<=`new_pc`, `pend`<=0. Ignores stall and `br_e`.
  2. `stall[0]==Stop`: `pc` holds. If `br_e`, then `pend`<=1 and `pend_addr`<=`br_addr`; a later `br_e` overwrites the buffered target.
  3. Not stalled, `br_e`: `pc`<=`br_addr`, `pend`<=0. A fresh branch beats a buffered one.
  4. Not stalled, `pend`: `pc`<=`pend_addr`, `pend`<=0.
  5. Otherwise `pc`<=`pc`+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- Two-state view:
  - `IDLE`: `pend`=0. Goes to `PEND` on stalled `br_e`.
  - `PEND`: `pend`=1. Returns to `IDLE` on any unstalled cycle or on `flush`.
- `excepttype` bits:
  - [31:1] driven 0; the IC stage fills [2:1].
  - [0] = fetch address error (see Configuration).
- `pc_to_ic_bus` and `inst_sram_addr`=`pc` are combinational from registers.

## Timing
- Reset: all outputs 0. On the first cycle after `rst` deasserts (no stall/flush), `pc`=RESET_VEC, `ce`=1, `inst_sram_en`=1.
- Latency:
  - Redirect: `br_e`/`flush` sampled at edge N; the new `pc` is visible after edge N.
  - Buffered redirect: applied on the first edge with `stall[0]==NoStop`.
- Simultaneous events:
  - `flush` + `br_e`: flush wins, branch dropped.
  - `flush` while `PEND`: buffer discarded.
  - `rst` mid-`PEND`: buffer cleared.
- While stalled, `inst_sram_en` and `inst_sram_addr` stay constant (request repeats).

## Configuration
- Macro: `PC_ADEL_CHECK_EN`.
- Defined:
  - `excepttype[0]` = `ce` & (`pc[1:0]`!=0).
  - `inst_sram_en` = `ce` & ~`excepttype[0]`, so no SRAM access to a misaligned address.
- Undefined:
  - `excepttype[0]`=0.
  - `inst_sram_en`=`ce`.

## Structure
- Shared constants in `lib/defines.vh`:
  - `StallBus`, `Stop`/`NoStop`, `ZeroWord`
  - `PC_TO_IC_WD`=65
  - reset-vector constant `RESET_PC`, which feeds `RESET_VEC`.
- One sub-module: `pc_redirect_buf`, holding `pend`/`pend_addr`, with capture/consume/clear controls and `pend`/`pend_addr` outputs.
- The top level holds the `pc`/`ce` register and the next-PC priority logic.

## Test plan
- Reset, then release with no stall: bus `pc` sequence 0xBFC00000, 0xBFC00004, 0xBFC00008; `ce`=1 from the first cycle.
- `br_e`=1, `br_addr`=0xBFC00100, unstalled: next `pc`=0xBFC00100, then 0xBFC00104.
- `stall[0]` held 3 cycles, `br_e` in cycle 1 (0x80000040) and cycle 2 (0x80000080):
  - `pc` frozen during the stall.
  - After release, `pc`=0x80000080.
- `flush` with `new_pc`=0xBFC00380 together with `br_e` (0x80001000) during `PEND`: `pc`=0xBFC00380, `pend`=0.
- `PC_ADEL_CHECK_EN` defined, `br_addr`=0x80000002:
  - `excepttype`=0x1, `inst_sram_en`=0.
  - Without the macro: `excepttype`=0, `inst_sram_en`=1.
- Wrap: flush to 0xFFFFFFFC, then one unstalled cycle: `pc`=0x00000000.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// Shared constants and types for the fetch PC generator.
// Holds the stall bus width, the stall encodings, the reset vector and the
// layout of the bus that goes to the instruction-cache stage.
package pc_gen_pkg;

    localparam int unsigned STALL_W     = 6;
    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned EXC_W       = 32;
    localparam int unsigned PC_TO_IC_WD = EXC_W + 1 + ADDR_W;

    localparam logic STOP   = 1'b1;
    localparam logic NOSTOP = 1'b0;

    localparam logic [ADDR_W-1:0] ZERO_WORD = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] RESET_PC  = 32'hBFC0_0000;
    localparam logic [ADDR_W-1:0] PC_STEP   = 32'h0000_0004;

    // Payload handed to the IC stage; field order sets the bit positions.
    typedef struct packed {
        logic [EXC_W-1:0]  excepttype;
        logic              ce;
        logic [ADDR_W-1:0] pc;
    } pc_to_ic_t;

    // Redirect buffer occupancy.
    typedef enum logic {
        BUF_IDLE = 1'b0,
        BUF_PEND = 1'b1
    } buf_state_e;

endpackage

// File: rtl/pc_redirect_buf.sv
// Holds one branch target that arrived while the PC was stalled.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   capture_i           : store capture_addr_i and mark the buffer pending
//   capture_addr_i      : target to store
//   consume_i           : the buffered target was applied to the PC
//   clear_i             : discard the buffered target (flush, fresh branch)
//   pend_o, pend_addr_o : buffer occupancy and stored target
module pc_redirect_buf
    import pc_gen_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              capture_i,
    input  logic [ADDR_W-1:0] capture_addr_i,
    input  logic              consume_i,
    input  logic              clear_i,
    output logic              pend_o,
    output logic [ADDR_W-1:0] pend_addr_o
);

    buf_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    // State and target registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BUF_IDLE;
            addr_q  <= ZERO_WORD;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    // Leaving PEND wins over capture; a repeated capture overwrites the target.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        if (clear_i || consume_i) begin
            state_d = BUF_IDLE;
        end else if (capture_i) begin
            state_d = BUF_PEND;
            addr_d  = capture_addr_i;
        end
    end

    assign pend_o      = (state_q == BUF_PEND);
    assign pend_addr_o = addr_q;

endmodule

// File: rtl/pc_gen.sv
// Instruction-fetch PC generator feeding the IC stage register.
// Selects the next PC from flush target, branch target, buffered branch
// target or PC+4, and drives the instruction SRAM request.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   stall          : stall bus, bit 0 == STOP freezes the PC
//   flush, new_pc  : exception/ERET redirect and its target
//   br_e, br_addr  : taken branch from EX and its target
//   pc_to_ic_bus   : {excepttype[31:0], ce, pc[31:0]}
//   inst_sram_en   : fetch request
//   inst_sram_addr : fetch address
// Build option: PC_ADEL_CHECK_EN flags misaligned fetch addresses in
// excepttype[0] and suppresses the SRAM request for them.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_VEC = RESET_PC
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [STALL_W-1:0]     stall,
    input  logic                   flush,
    input  logic [ADDR_W-1:0]      new_pc,
    input  logic                   br_e,
    input  logic [ADDR_W-1:0]      br_addr,
    output logic [PC_TO_IC_WD-1:0] pc_to_ic_bus,
    output logic                   inst_sram_en,
    output logic [ADDR_W-1:0]      inst_sram_addr
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              ce_q, ce_d;
    logic              buf_capture, buf_consume, buf_clear;
    logic              pend;
    logic [ADDR_W-1:0] pend_addr;
    logic              adel;
    logic [ADDR_W-1:0] pc_out;
    pc_to_ic_t         bus;

    // Only bit 0 of the stall bus concerns this stage.
    logic unused_stall_hi;
    assign unused_stall_hi = ^stall[STALL_W-1:1];

    pc_redirect_buf u_redirect_buf (
        .clk            (clk),
        .rst            (rst),
        .capture_i      (buf_capture),
        .capture_addr_i (br_addr),
        .consume_i      (buf_consume),
        .clear_i        (buf_clear),
        .pend_o         (pend),
        .pend_addr_o    (pend_addr)
    );

    // PC and fetch-enable registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_VEC - PC_STEP;
            ce_q <= 1'b0;
        end else begin
            pc_q <= pc_d;
            ce_q <= ce_d;
        end
    end

    // Next-PC priority: flush, stall, fresh branch, buffered branch, PC+4.
    always_comb begin
        pc_d        = pc_q;
        ce_d        = 1'b1;
        buf_capture = 1'b0;
        buf_consume = 1'b0;
        buf_clear   = 1'b0;
        if (flush) begin
            pc_d      = new_pc;
            buf_clear = 1'b1;
        end else if (stall[0] == STOP) begin
            buf_capture = br_e;
        end else if (br_e) begin
            pc_d      = br_addr;
            buf_clear = 1'b1;
        end else if (pend) begin
            pc_d        = pend_addr;
            buf_consume = 1'b1;
        end else begin
            pc_d = pc_q + PC_STEP;
        end
    end

`ifdef PC_ADEL_CHECK_EN
    assign adel = ce_q & (pc_q[1:0] != 2'b00);
`else
    assign adel = 1'b0;
`endif

    // Address is forced to zero while fetch is disabled so reset shows all zeros.
    assign pc_out = ce_q ? pc_q : ZERO_WORD;

    always_comb begin
        bus            = '0;
        bus.excepttype = {31'b0, adel};
        bus.ce         = ce_q;
        bus.pc         = pc_out;
    end

    assign pc_to_ic_bus   = PC_TO_IC_WD'(bus);
    assign inst_sram_en   = ce_q & ~adel;
    assign inst_sram_addr = pc_out;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: directed scenarios followed by random stimulus,
// expectations produced by a behavioural model and checked by a monitor.
module tb_pc_gen;
    import pc_gen_pkg::*;

    localparam logic [31:0] RV = 32'hBFC0_0000;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [STALL_W-1:0]     stall;
    logic                   flush;
    logic [31:0]            new_pc;
    logic                   br_e;
    logic [31:0]            br_addr;
    logic [PC_TO_IC_WD-1:0] pc_to_ic_bus;
    logic                   inst_sram_en;
    logic [31:0]            inst_sram_addr;

    pc_gen #(.RESET_VEC(RV)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .flush          (flush),
        .new_pc         (new_pc),
        .br_e           (br_e),
        .br_addr        (br_addr),
        .pc_to_ic_bus   (pc_to_ic_bus),
        .inst_sram_en   (inst_sram_en),
        .inst_sram_addr (inst_sram_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [64:0] bus;
        logic        en;
        logic [31:0] addr;
        string       tag;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    // Reference state: current fetch PC, enable, and list of targets seen while stalled.
    logic [31:0] m_pc;
    logic        m_ce;
    logic [31:0] m_pend[$];
    string       cur_tag = "reset";

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    // Apply one cycle of inputs and record what the outputs must be after the edge.
    task automatic step(input logic r, input logic s0, input logic f, input logic [31:0] np,
                        input logic b, input logic [31:0] ba);
        exp_t        e;
        logic        exc;
        logic [31:0] a;
        @(negedge clk);
        rst     = r;
        stall   = {STALL_W'($urandom) >> 1, s0} ;
        stall[0] = s0;
        flush   = f;
        new_pc  = np;
        br_e    = b;
        br_addr = ba;
        if (r) begin
            m_pc = RV - 32'd4;
            m_ce = 1'b0;
            m_pend.delete();
        end else begin
            m_ce = 1'b1;
            if (f) begin
                m_pc = np;
                m_pend.delete();
            end else if (s0) begin
                if (b) m_pend.push_back(ba);
            end else if (b) begin
                m_pc = ba;
                m_pend.delete();
            end else if (m_pend.size() != 0) begin
                m_pc = m_pend[$];
                m_pend.delete();
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end
`ifdef PC_ADEL_CHECK_EN
        exc = m_ce && (m_pc % 4 != 0);
`else
        exc = 1'b0;
`endif
        a      = m_ce ? m_pc : 32'h0;
        e.bus  = {31'b0, exc, m_ce, a};
        e.en   = m_ce && !exc;
        e.addr = a;
        e.tag  = cur_tag;
        exp_q.push_back(e);
    endtask

    task automatic run(input logic s0, input logic b, input logic [31:0] ba);
        step(1'b0, s0, 1'b0, 32'h0, b, ba);
    endtask

    // Monitor: every cycle after the edge, compare against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check({e.tag, " bus"},  pc_to_ic_bus, e.bus);
                check({e.tag, " en"},   65'(inst_sram_en), 65'(e.en));
                check({e.tag, " addr"}, 65'(inst_sram_addr), 65'(e.addr));
            end
        end
    end

    initial begin
        logic [31:0] ra;
        int          wait_cyc;
        rst = 1'b1; stall = '0; flush = 1'b0; new_pc = '0; br_e = 1'b0; br_addr = '0;
        m_pc = RV - 32'd4; m_ce = 1'b0;

        cur_tag = "reset";      step(1, 0, 0, 0, 0, 0); step(1, 0, 0, 0, 0, 0);
        cur_tag = "seq";        run(0, 0, 0); run(0, 0, 0); run(0, 0, 0);
        cur_tag = "branch";     run(0, 1, 32'hBFC0_0100); run(0, 0, 0);
        cur_tag = "stall_buf";  run(1, 1, 32'h8000_0040); run(1, 1, 32'h8000_0080);
                                run(1, 0, 0); run(0, 0, 0); run(0, 0, 0);
        cur_tag = "flush_pend"; run(1, 1, 32'h8000_0040);
                                step(0, 1, 1, 32'hBFC0_0380, 1, 32'h8000_1000);
                                run(0, 0, 0);
        cur_tag = "fresh_wins"; run(1, 1, 32'h8000_0200); run(0, 1, 32'h8000_0300); run(0, 0, 0);
        cur_tag = "misalign";   run(0, 1, 32'h8000_0002); run(0, 0, 0);
        cur_tag = "wrap";       step(0, 0, 1, 32'hFFFF_FFFC, 0, 0); run(0, 0, 0);
        cur_tag = "rst_pend";   run(1, 1, 32'h8000_0500); step(1, 1, 0, 0, 0, 0);
                                run(0, 0, 0); run(0, 0, 0);

        cur_tag = "random";
        for (int i = 0; i < 2000; i++) begin
            ra = {$urandom_range(0, 3) == 0 ? $urandom : 32'h8000_0000 | ($urandom & 32'h0000_FFFC)};
            if ($urandom_range(0, 7) == 0) ra[1:0] = 2'($urandom_range(1, 3));
            step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 35),
                 ($urandom_range(0, 99) < 5), $urandom & 32'hFFFF_FFFC,
                 ($urandom_range(0, 99) < 30), ra);
        end

        wait_cyc = 0;
        while (exp_q.size() != 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        #2;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
